// File: rtl/control_unit.sv
// ============================================================================
// Module      : control_unit
// Description : Multi-cycle MIPS-style control FSM. It drives the datapath
//               enables and mux selects from the current state and the decoded
//               opcode/funct.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit #(
    parameter logic [5:0] GPIN_OPCODE = 6'b111111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PC_En,
    output logic       I_or_D,
    output logic       Mem_Write,
    output logic       IR_Write,
    output logic       Reg_Write,
    output logic [1:0] Reg_Dst,
    output logic [1:0] Mem_to_Reg,
    output logic       ALU_Src_A,
    output logic [1:0] ALU_Src_B,
    output logic [1:0] PC_Src,
    output logic [2:0] ALU_Control,
    output logic       Retire,
    output logic       Illegal_Instr
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_FN_JR    = 6'b001000;

    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADR   = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        ADDI_EX   = 4'd9,
        ADDI_WB   = 4'd10,
        JUMP      = 4'd11,
        JR        = 4'd12,
        GPIN_WB   = 4'd13
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_funct_ok;
    logic [2:0] w_funct_alu;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // R-type funct decode, shared by DECODE (legality) and EXECUTE (ALU op)
    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = c_ALU_ADD;
        case (Funct)
            6'b100000, 6'b100001: w_funct_alu = c_ALU_ADD;
            6'b100010, 6'b100011: w_funct_alu = c_ALU_SUB;
            6'b100100:            w_funct_alu = c_ALU_AND;
            6'b100101:            w_funct_alu = c_ALU_OR;
            6'b101010:            w_funct_alu = c_ALU_SLT;
            default:              w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_next        = FETCH;
        PC_En         = 1'b0;
        I_or_D        = 1'b0;
        Mem_Write     = 1'b0;
        IR_Write      = 1'b0;
        Reg_Write     = 1'b0;
        Reg_Dst       = 2'b00;
        Mem_to_Reg    = 2'b00;
        ALU_Src_A     = 1'b0;
        ALU_Src_B     = 2'b00;
        PC_Src        = 2'b00;
        ALU_Control   = c_ALU_ADD;
        Retire        = 1'b0;
        Illegal_Instr = 1'b0;

        case (r_state)
            FETCH: begin
                IR_Write  = 1'b1;
                ALU_Src_B = 2'b01;
                PC_En     = 1'b1;
                w_next    = DECODE;
            end
            DECODE: begin
                ALU_Src_B = 2'b11;
                case (Op)
                    c_OP_LW, c_OP_SW:   w_next = MEM_ADR;
                    c_OP_BEQ, c_OP_BNE: w_next = BRANCH;
                    c_OP_ADDI:          w_next = ADDI_EX;
                    c_OP_J:             w_next = JUMP;
                    c_OP_JAL: begin
                        // Link register gets PC+4, still held in ALU_Out from FETCH
                        Reg_Write = 1'b1;
                        Reg_Dst   = 2'b10;
                        w_next    = JUMP;
                    end
                    c_OP_RTYPE: begin
                        if (Funct == c_FN_JR) begin
                            w_next = JR;
                        end else if (w_funct_ok) begin
                            w_next = EXECUTE;
                        end else begin
                            Illegal_Instr = 1'b1;
                            Retire        = 1'b1;
                        end
                    end
                    default: begin
                        if (Op == GPIN_OPCODE) begin
                            w_next = GPIN_WB;
                        end else begin
                            Illegal_Instr = 1'b1;
                            Retire        = 1'b1;
                        end
                    end
                endcase
            end
            MEM_ADR: begin
                ALU_Src_A = 1'b1;
                ALU_Src_B = 2'b10;
                w_next    = (Op == c_OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                I_or_D = 1'b1;
                w_next = MEM_WB;
            end
            MEM_WB: begin
                Mem_to_Reg = 2'b01;
                Reg_Write  = 1'b1;
                Retire     = 1'b1;
            end
            MEM_WRITE: begin
                I_or_D    = 1'b1;
                Mem_Write = 1'b1;
                Retire    = 1'b1;
            end
            EXECUTE: begin
                ALU_Src_A   = 1'b1;
                ALU_Control = w_funct_alu;
                w_next      = ALU_WB;
            end
            ALU_WB: begin
                Reg_Dst   = 2'b01;
                Reg_Write = 1'b1;
                Retire    = 1'b1;
            end
            BRANCH: begin
                ALU_Src_A   = 1'b1;
                ALU_Control = c_ALU_SUB;
                PC_Src      = 2'b01;
                PC_En       = (Op == c_OP_BNE) ? ~Zero : Zero;
                Retire      = 1'b1;
            end
            ADDI_EX: begin
                ALU_Src_A = 1'b1;
                ALU_Src_B = 2'b10;
                w_next    = ADDI_WB;
            end
            ADDI_WB: begin
                Reg_Write = 1'b1;
                Retire    = 1'b1;
            end
            JUMP: begin
                PC_Src = 2'b10;
                PC_En  = 1'b1;
                Retire = 1'b1;
            end
            JR: begin
                // rt is $0 in the jr encoding, so A + B is just rs
                ALU_Src_A = 1'b1;
                PC_En     = 1'b1;
                Retire    = 1'b1;
            end
            GPIN_WB: begin
                Mem_to_Reg = 2'b10;
                Reg_Write  = 1'b1;
                Retire     = 1'b1;
            end
            default: w_next = FETCH;
        endcase

        if (reset) begin
            PC_En         = 1'b0;
            IR_Write      = 1'b0;
            Mem_Write     = 1'b0;
            Reg_Write     = 1'b0;
            Retire        = 1'b0;
            Illegal_Instr = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module      : tb_control_unit
// Description : Self-checking bench for control_unit: per-instruction cycle
//               expectations from a step-indexed instruction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    localparam logic [5:0] c_GPIN = 6'b111111;
    localparam logic [5:0] c_LW   = 6'b100011;
    localparam logic [5:0] c_SW   = 6'b101011;
    localparam logic [5:0] c_BEQ  = 6'b000100;
    localparam logic [5:0] c_BNE  = 6'b000101;
    localparam logic [5:0] c_ADDI = 6'b001000;
    localparam logic [5:0] c_J    = 6'b000010;
    localparam logic [5:0] c_JAL  = 6'b000011;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic       retire;
        logic       illegal;
    } out_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        int         zmode;
        int         lat;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PC_En, I_or_D, Mem_Write, IR_Write, Reg_Write, ALU_Src_A, Retire, Illegal_Instr;
    logic [1:0] Reg_Dst, Mem_to_Reg, ALU_Src_B, PC_Src;
    logic [2:0] ALU_Control;
    out_t       act;

    int n_checks = 0;
    int n_fail   = 0;

    control_unit #(.GPIN_OPCODE(c_GPIN)) dut (
        .clk          (clk),
        .reset        (reset),
        .Op           (Op),
        .Funct        (Funct),
        .Zero         (Zero),
        .PC_En        (PC_En),
        .I_or_D       (I_or_D),
        .Mem_Write    (Mem_Write),
        .IR_Write     (IR_Write),
        .Reg_Write    (Reg_Write),
        .Reg_Dst      (Reg_Dst),
        .Mem_to_Reg   (Mem_to_Reg),
        .ALU_Src_A    (ALU_Src_A),
        .ALU_Src_B    (ALU_Src_B),
        .PC_Src       (PC_Src),
        .ALU_Control  (ALU_Control),
        .Retire       (Retire),
        .Illegal_Instr(Illegal_Instr)
    );

    assign act = {PC_En, I_or_D, Mem_Write, IR_Write, Reg_Write, Reg_Dst, Mem_to_Reg,
                  ALU_Src_A, ALU_Src_B, PC_Src, ALU_Control, Retire, Illegal_Instr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000)
            return fn inside {6'b001000, 6'b100000, 6'b100001, 6'b100010,
                              6'b100011, 6'b100100, 6'b100101, 6'b101010};
        return op inside {c_LW, c_SW, c_BEQ, c_BNE, c_ADDI, c_J, c_JAL, c_GPIN};
    endfunction

    function automatic int model_lat(input logic [5:0] op, input logic [5:0] fn);
        if (!is_legal(op, fn))  return 2;
        if (op == c_LW)         return 5;
        if (op == c_SW)         return 4;
        if (op == c_ADDI)       return 4;
        if (op == 6'b000000)    return (fn == 6'b001000) ? 3 : 4;
        return 3;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100010, 6'b100011: return 3'b110;
            6'b100100:            return 3'b000;
            6'b100101:            return 3'b001;
            6'b101010:            return 3'b111;
            default:              return 3'b010;
        endcase
    endfunction

    // Expected outputs for cycle `step` (0 = first cycle) of one instruction
    function automatic out_t exp_vec(input logic [5:0] op, input logic [5:0] fn,
                                     input logic z, input int step);
        out_t o;
        o = '0;
        o.alu_control = 3'b010;
        if (step == 0) begin
            o.ir_write = 1; o.alu_src_b = 2'b01; o.pc_en = 1;
        end else if (step == 1) begin
            o.alu_src_b = 2'b11;
            if (op == c_JAL) begin o.reg_write = 1; o.reg_dst = 2'b10; end
            if (!is_legal(op, fn)) begin o.illegal = 1; o.retire = 1; end
        end else if (op == c_LW || op == c_SW) begin
            if (step == 2) begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            else if (step == 3) begin
                o.i_or_d = 1;
                if (op == c_SW) begin o.mem_write = 1; o.retire = 1; end
            end else begin
                o.reg_write = 1; o.mem_to_reg = 2'b01; o.retire = 1;
            end
        end else if (op == 6'b000000 && fn == 6'b001000) begin
            o.alu_src_a = 1; o.pc_en = 1; o.retire = 1;
        end else if (op == 6'b000000) begin
            if (step == 2) begin o.alu_src_a = 1; o.alu_control = funct_alu(fn); end
            else begin o.reg_dst = 2'b01; o.reg_write = 1; o.retire = 1; end
        end else if (op == c_BEQ || op == c_BNE) begin
            o.alu_src_a = 1; o.alu_control = 3'b110; o.pc_src = 2'b01; o.retire = 1;
            o.pc_en = (op == c_BNE) ? !z : z;
        end else if (op == c_ADDI) begin
            if (step == 2) begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            else begin o.reg_write = 1; o.retire = 1; end
        end else if (op == c_J || op == c_JAL) begin
            o.pc_src = 2'b10; o.pc_en = 1; o.retire = 1;
        end else begin
            o.mem_to_reg = 2'b10; o.reg_write = 1; o.retire = 1;
        end
        return o;
    endfunction

    function automatic out_t mask_rst(input out_t o);
        out_t m;
        m = o;
        m.pc_en = 0; m.ir_write = 0; m.mem_write = 0;
        m.reg_write = 0; m.retire = 0; m.illegal = 0;
        return m;
    endfunction

    // ---------------- check helpers ----------------
    task automatic check_vec(input string name, input out_t got, input out_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Runs `cycles` cycles of one instruction starting from posedge+1 in FETCH.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input int zmode, input int cycles, output int ret_step);
        ret_step = -1;
        for (int s = 0; s < cycles; s++) begin
            Op    = op;
            Funct = fn;
            Zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            @(negedge clk);
            check_vec($sformatf("%s step%0d", name, s), act, exp_vec(op, fn, Zero, s));
            if (Retire === 1'b1 && ret_step < 0) ret_step = s + 1;
            @(posedge clk);
            #1;
        end
    endtask

    vec_t tbl[20];
    logic [5:0] rand_ops[12];
    logic [5:0] good_fn[8];

    initial begin
        int rs;
        tbl[0]  = '{"lw",        c_LW,      6'b000000, 0, 5};
        tbl[1]  = '{"sw",        c_SW,      6'b000000, 0, 4};
        tbl[2]  = '{"add",       6'b000000, 6'b100000, 0, 4};
        tbl[3]  = '{"addu",      6'b000000, 6'b100001, 0, 4};
        tbl[4]  = '{"sub",       6'b000000, 6'b100010, 0, 4};
        tbl[5]  = '{"subu",      6'b000000, 6'b100011, 0, 4};
        tbl[6]  = '{"and",       6'b000000, 6'b100100, 0, 4};
        tbl[7]  = '{"or",        6'b000000, 6'b100101, 0, 4};
        tbl[8]  = '{"slt",       6'b000000, 6'b101010, 0, 4};
        tbl[9]  = '{"jr",        6'b000000, 6'b001000, 0, 3};
        tbl[10] = '{"beq_z1",    c_BEQ,     6'b000000, 1, 3};
        tbl[11] = '{"beq_z0",    c_BEQ,     6'b000000, 0, 3};
        tbl[12] = '{"bne_z1",    c_BNE,     6'b000000, 1, 3};
        tbl[13] = '{"bne_z0",    c_BNE,     6'b000000, 0, 3};
        tbl[14] = '{"addi",      c_ADDI,    6'b000000, 0, 4};
        tbl[15] = '{"j",         c_J,       6'b000000, 0, 3};
        tbl[16] = '{"jal",       c_JAL,     6'b000000, 0, 3};
        tbl[17] = '{"gpin",      c_GPIN,    6'b000000, 0, 3};
        tbl[18] = '{"ill_op",    6'b111110, 6'b000000, 0, 2};
        tbl[19] = '{"ill_funct", 6'b000000, 6'b000111, 0, 2};

        rand_ops = '{c_LW, c_SW, 6'b000000, 6'b000000, 6'b000000, c_BEQ,
                     c_BNE, c_ADDI, c_J, c_JAL, c_GPIN, 6'b000000};
        good_fn  = '{6'b001000, 6'b100000, 6'b100001, 6'b100010,
                     6'b100011, 6'b100100, 6'b100101, 6'b101010};

        reset = 1'b1;
        Op    = 6'b000000;
        Funct = 6'b000000;
        Zero  = 1'b0;

        // Reset state: FETCH selects, all enables held low
        @(posedge clk); #1;
        @(negedge clk);
        check_vec("reset_state", act, mask_rst(exp_vec(c_LW, 6'b0, 1'b0, 0)));
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            run_instr(tbl[i].name, tbl[i].op, tbl[i].funct, tbl[i].zmode, tbl[i].lat, rs);
            check_int({tbl[i].name, " latency"}, rs, tbl[i].lat);
        end

        // Reset during MEM_WRITE: store suppressed, back to FETCH next cycle
        run_instr("sw_pre_rst", c_SW, 6'b0, 0, 3, rs);
        reset = 1'b1;
        @(negedge clk);
        check_int("rst_mem_write", int'(Mem_Write), 0);
        check_vec("rst_in_mem_write", act, mask_rst(exp_vec(c_SW, 6'b0, 1'b0, 3)));
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr("lw_after_rst", c_LW, 6'b0, 0, 5, rs);
        check_int("lw_after_rst latency", rs, 5);

        // Reset during jal DECODE: link write suppressed
        run_instr("jal_pre_rst", c_JAL, 6'b0, 0, 1, rs);
        reset = 1'b1;
        @(negedge clk);
        check_vec("rst_in_jal_decode", act, mask_rst(exp_vec(c_JAL, 6'b0, 1'b0, 1)));
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr("bne_after_rst", c_BNE, 6'b0, 1, 3, rs);

        // Randomized instruction stream against the model
        for (int k = 0; k < 150; k++) begin
            logic [5:0] op, fn;
            int lat;
            op = rand_ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 63));
            fn = good_fn[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 63));
            lat = model_lat(op, fn);
            run_instr($sformatf("rand%0d op%b fn%b", k, op, fn), op, fn, 2, lat, rs);
            check_int($sformatf("rand%0d latency", k), rs, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
